// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;
  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  typedef struct packed {
    owner_e                owner;
    logic                  we;
    logic [ARB_AW-1:0]     addr;
    logic [ARB_DW-1:0]     wdata;
    logic [ARB_DW/8-1:0]   strb;
  } issue_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port; slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              if_req_i;
  logic [AWIDTH-1:0] if_addr_i;
  logic              if_flush_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DWIDTH-1:0] if_rdata_o;
  logic              if_err_o;

  logic                dm_req_i;
  logic                dm_we_i;
  logic [AWIDTH-1:0]   dm_addr_i;
  logic [DWIDTH-1:0]   dm_wdata_i;
  logic [DWIDTH/8-1:0] dm_strb_i;
  logic                dm_gnt_o;
  logic                dm_rvalid_o;
  logic [DWIDTH-1:0]   dm_rdata_o;
  logic                dm_err_o;

  logic [AWIDTH-1:0]   mem_addr_o;
  logic [DWIDTH-1:0]   mem_data_o;
  logic [DWIDTH/8-1:0] mem_strb_o;
  logic                mem_read_en_o;
  logic                mem_write_en_o;
  logic [DWIDTH-1:0]   mem_data_i;
  logic                mem_vld_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_strb_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
    output mem_addr_o, mem_data_o, mem_strb_o, mem_read_en_o, mem_write_en_o,
    input  mem_data_i, mem_vld_i
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_strb_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
    input  mem_addr_o, mem_data_o, mem_strb_o, mem_read_en_o, mem_write_en_o,
    output mem_data_i, mem_vld_i
  );
endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive denied fetch cycles; starve_o lets fetch win the next arbitration.
module mem_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic gnt_i,
  output logic starve_o
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i)  cnt_d = '0;
    else if (cnt_q != LIM) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign starve_o = (cnt_q == LIM);
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the unified memory port: grant -> issue -> response, 2-cycle latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH       = ARB_AW,
  parameter int DWIDTH       = ARB_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);
  logic   starve;
  logic   if_gnt, dm_gnt;
  issue_t iss_q, iss_d;
  logic   iss_rd;

  owner_e            rsp_own_q;
  logic [DWIDTH-1:0] rsp_data_q;
  logic              rsp_err_q;

  mem_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus.if_req_i),
    .gnt_i    (if_gnt),
    .starve_o (starve)
  );

  // Data side wins ties unless fetch has been starved for the full limit.
  assign if_gnt = !rst && bus.if_req_i && (!bus.dm_req_i || starve);
  assign dm_gnt = !rst && bus.dm_req_i && !(bus.if_req_i && starve);

  assign bus.if_gnt_o = if_gnt;
  assign bus.dm_gnt_o = dm_gnt;

  always_comb begin
    iss_d = '0;
    if (dm_gnt) begin
      iss_d.owner = OWN_DM;
      iss_d.we    = bus.dm_we_i;
      iss_d.addr  = bus.dm_addr_i;
      iss_d.wdata = bus.dm_we_i ? bus.dm_wdata_i : '0;
      iss_d.strb  = bus.dm_we_i ? bus.dm_strb_i  : '0;
    end else if (if_gnt) begin
      // A fetch granted under flush is accepted but never issued.
      iss_d.owner = bus.if_flush_i ? OWN_NONE : OWN_IF;
      iss_d.addr  = bus.if_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) iss_q <= '0;
    else     iss_q <= iss_d;
  end

  assign iss_rd             = (iss_q.owner != OWN_NONE) && !iss_q.we;
  assign bus.mem_addr_o     = iss_q.addr;
  assign bus.mem_data_o     = iss_q.wdata;
  assign bus.mem_read_en_o  = iss_rd;
  assign bus.mem_write_en_o = (iss_q.owner == OWN_DM) && iss_q.we;
  assign bus.mem_strb_o     = bus.mem_write_en_o ? iss_q.strb : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_own_q  <= OWN_NONE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_own_q  <= (iss_q.owner == OWN_IF && bus.if_flush_i) ? OWN_NONE : iss_q.owner;
      rsp_data_q <= (iss_rd && bus.mem_vld_i) ? bus.mem_data_i : '0;
      rsp_err_q  <= iss_rd && !bus.mem_vld_i;
    end
  end

  // Flush also squashes a fetch response landing in the same cycle.
  assign bus.if_rvalid_o = (rsp_own_q == OWN_IF) && !bus.if_flush_i;
  assign bus.if_rdata_o  = (rsp_own_q == OWN_IF) ? rsp_data_q : '0;
  assign bus.if_err_o    = bus.if_rvalid_o && rsp_err_q;

  assign bus.dm_rvalid_o = (rsp_own_q == OWN_DM);
  assign bus.dm_rdata_o  = bus.dm_rvalid_o ? rsp_data_q : '0;
  assign bus.dm_err_o    = bus.dm_rvalid_o && rsp_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory mapped at 0x01000000.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:1023];
  logic        in_rng;
  logic [9:0]  widx;

  assign in_rng         = (bus.mem_addr_o[31:12] == 20'h01000);
  assign widx           = bus.mem_addr_o[11:2];
  assign bus.mem_vld_i  = in_rng;
  assign bus.mem_data_i = in_rng ? mem[widx] : 32'hBADBAD00;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h11111111 * (i + 1);
    end else if (bus.mem_write_en_o && in_rng) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_strb_o[b]) mem[widx][b*8 +: 8] <= bus.mem_data_o[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.if_flush_i = 1'b0;
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_addr_i  = '0;
    bus.dm_wdata_i = '0;
    bus.dm_strb_i  = '0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = a;
  endtask

  task automatic dm_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = we;
    bus.dm_addr_i  = a;
    bus.dm_wdata_i = d;
    bus.dm_strb_i  = s;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ifgnt"},  {31'd0, bus.if_gnt_o}, 32'd0);
    chk({tag, "_dmgnt"},  {31'd0, bus.dm_gnt_o}, 32'd0);
    chk({tag, "_ifrv"},   {31'd0, bus.if_rvalid_o}, 32'd0);
    chk({tag, "_dmrv"},   {31'd0, bus.dm_rvalid_o}, 32'd0);
    chk({tag, "_rden"},   {31'd0, bus.mem_read_en_o}, 32'd0);
    chk({tag, "_wren"},   {31'd0, bus.mem_write_en_o}, 32'd0);
    chk({tag, "_maddr"},  bus.mem_addr_o, 32'd0);
    chk({tag, "_dmrd"},   bus.dm_rdata_o, 32'd0);
    chk({tag, "_ifrd"},   bus.if_rdata_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.if_req_i = 1'b1;
    bus.dm_req_i = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    chk_quiet("rst0");
    cyc(); idle(); rst = 1'b0;
    smp();

    // fetch-only back-to-back
    cyc(); fetch(32'h01000000); smp(); chk("t1_gnt0", {31'd0, bus.if_gnt_o}, 32'd1);
    cyc(); fetch(32'h01000004); smp(); chk("t1_gnt1", {31'd0, bus.if_gnt_o}, 32'd1);
    cyc(); idle(); smp();
    chk("t1_rv0", {31'd0, bus.if_rvalid_o}, 32'd1);
    chk("t1_rd0", bus.if_rdata_o, 32'h11111111);
    chk("t1_err0", {31'd0, bus.if_err_o}, 32'd0);
    chk("t1_dmrv0", {31'd0, bus.dm_rvalid_o}, 32'd0);
    cyc(); smp();
    chk("t1_rv1", {31'd0, bus.if_rvalid_o}, 32'd1);
    chk("t1_rd1", bus.if_rdata_o, 32'h22222222);
    cyc(); smp();
    chk("t1_rv2", {31'd0, bus.if_rvalid_o}, 32'd0);

    // continuous contention: fetch wins every 5th cycle
    for (int i = 0; i < 10; i++) begin
      cyc(); fetch(32'h01000000); dm_op(1'b0, 32'h01000020, 32'd0, 4'd0); smp();
      chk($sformatf("t2_if%0d", i), {31'd0, bus.if_gnt_o}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("t2_dm%0d", i), {31'd0, bus.dm_gnt_o}, (i == 4 || i == 9) ? 32'd0 : 32'd1);
    end
    cyc(); idle(); smp();
    cyc(); smp();
    cyc(); smp();

    // store then load to same word
    cyc(); dm_op(1'b1, 32'h01000010, 32'hDEADBEEF, 4'b0011); smp();
    chk("t3_sgnt", {31'd0, bus.dm_gnt_o}, 32'd1);
    cyc(); dm_op(1'b0, 32'h01000010, 32'd0, 4'd0); smp();
    chk("t3_lgnt", {31'd0, bus.dm_gnt_o}, 32'd1);
    chk("t3_wren", {31'd0, bus.mem_write_en_o}, 32'd1);
    chk("t3_strb", {28'd0, bus.mem_strb_o}, 32'h3);
    chk("t3_wdat", bus.mem_data_o, 32'hDEADBEEF);
    chk("t3_waddr", bus.mem_addr_o, 32'h01000010);
    cyc(); idle(); smp();
    chk("t3_ackrv", {31'd0, bus.dm_rvalid_o}, 32'd1);
    chk("t3_ackrd", bus.dm_rdata_o, 32'd0);
    chk("t3_ackerr", {31'd0, bus.dm_err_o}, 32'd0);
    cyc(); smp();
    chk("t3_ldrv", {31'd0, bus.dm_rvalid_o}, 32'd1);
    chk("t3_ldrd", bus.dm_rdata_o, 32'h5555BEEF);

    // unmapped fetch
    cyc(); fetch(32'h00000100); smp();
    cyc(); idle(); smp();
    cyc(); smp();
    chk("t4_rv", {31'd0, bus.if_rvalid_o}, 32'd1);
    chk("t4_err", {31'd0, bus.if_err_o}, 32'd1);
    chk("t4_rd", bus.if_rdata_o, 32'd0);

    // flush while fetch is in issue, then a normal fetch
    cyc(); fetch(32'h01000008); smp();
    cyc(); idle(); bus.if_flush_i = 1'b1; smp();
    cyc(); bus.if_flush_i = 1'b0; fetch(32'h0100000C); smp();
    chk("t5_killrv", {31'd0, bus.if_rvalid_o}, 32'd0);
    chk("t5_gnt", {31'd0, bus.if_gnt_o}, 32'd1);
    cyc(); idle(); smp();
    cyc(); smp();
    chk("t5_rv", {31'd0, bus.if_rvalid_o}, 32'd1);
    chk("t5_rd", bus.if_rdata_o, 32'h44444444);

    // flush in the grant cycle
    cyc(); fetch(32'h01000000); bus.if_flush_i = 1'b1; smp();
    chk("t5b_gnt", {31'd0, bus.if_gnt_o}, 32'd1);
    cyc(); idle(); smp();
    cyc(); smp();
    chk("t5b_rv", {31'd0, bus.if_rvalid_o}, 32'd0);

    // flush in the response cycle
    cyc(); fetch(32'h01000000); smp();
    cyc(); idle(); smp();
    cyc(); bus.if_flush_i = 1'b1; smp();
    chk("t5c_rv", {31'd0, bus.if_rvalid_o}, 32'd0);
    cyc(); idle(); smp();

    // reset right after a load grant
    cyc(); dm_op(1'b0, 32'h01000000, 32'd0, 4'd0); smp();
    chk("t6_gnt", {31'd0, bus.dm_gnt_o}, 32'd1);
    cyc(); rst = 1'b1; fetch(32'h01000000); smp();
    chk_quiet("t6_rst");
    cyc(); idle(); rst = 1'b0; smp();
    chk("t6_rv0", {31'd0, bus.dm_rvalid_o}, 32'd0);
    cyc(); smp();
    chk("t6_rv1", {31'd0, bus.dm_rvalid_o}, 32'd0);
    cyc(); smp();
    chk("t6_rv2", {31'd0, bus.dm_rvalid_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single byte-addressable unified memory port between instruction fetch and the load/store stage of the pipelined RV32I core. It selects one request per cycle, registers it into an issue stage that drives the memory, and returns read data or write acknowledgement to the owning requester two cycles after grant. The data port has priority, and a starvation counter bounds how long fetch can be held off.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width; strobe width DWIDTH/8
- STARVE_LIMIT, 4, consecutive denied fetch-request cycles before fetch wins one arbitration (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request
- if_addr_i  in  AWIDTH  fetch address
- if_flush_i  in  1  discard any in-flight fetch
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  DWIDTH  fetch data
- if_err_o  out  1  fetch hit unmapped address (qualifies if_rvalid_o)
- dm_req_i  in  1  data request
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  AWIDTH  data address
- dm_wdata_i  in  DWIDTH  store data
- dm_strb_i  in  DWIDTH/8  store byte strobes
- dm_gnt_o  out  1  data request accepted
- dm_rvalid_o  out  1  load data / store ack valid
- dm_rdata_o  out  DWIDTH  load data (0 on store)
- dm_err_o  out  1  unmapped address
- mem_addr_o  out  AWIDTH  memory address
- mem_data_o  out  DWIDTH  memory write data
- mem_strb_o  out  DWIDTH/8  memory write strobes
- mem_read_en_o  out  1  memory read enable
- mem_write_en_o  out  1  memory write enable
- mem_data_i  in  DWIDTH  memory combinational read data
- mem_vld_i  in  1  memory read data valid (low = out of range)

## Operation
- Requester holds req and payload stable until gnt; gnt is combinational in the same cycle; at most one gnt per cycle.
- Arbitration: dm wins when both request, unless starve count == STARVE_LIMIT, in which case if wins.
- Starve counter: +1 (saturating at STARVE_LIMIT) each cycle if_req_i=1 and if_gnt_o=0; cleared on if_gnt_o or if_req_i=0.
- Issue stage (owner ∈ {NONE, IF, DM}, addr, wdata, strb, we): loaded on any gnt, else owner←NONE.
- Issue stage drives memory: read_en = owner≠NONE && !we; write_en = owner==DM && we; store strobes passed through; loads/fetches drive mem_strb_o=0.
- Response stage captures mem_data_i and !mem_vld_i for reads; rvalid pulses to the owner one cycle later; store ack carries rdata=0 and err=0.
- The memory itself drops out-of-range writes; the arbiter does not flag them.
- if_flush_i: fetch entries in issue or response stage are killed (no if_rvalid_o). A fetch granted in the same cycle as flush is also killed. Data traffic is unaffected.

## Timing
- Grant cycle N → memory access N+1 → rvalid N+2. Throughput is one access per cycle, fully pipelined, with no stall input.
- Store commits at the clk edge ending N+1. A load granted at N+1 to the same address sees the new data.
- Reset (async): issue/response owner=NONE, counter=0. All rvalid/err/rdata/mem_* outputs are 0. gnt outputs are forced 0 while rst is high.
- Reset mid-operation drops all in-flight transactions; no response is produced after deassert.
- Simultaneous flush and if rvalid in the same cycle: rvalid is suppressed.

## Structure
- Package mem_arb_pkg: owner_e enum (OWN_NONE, OWN_IF, OWN_DM), issue_t struct (owner, we, addr, wdata, strb).
- Sub-module mem_arb_starve_cnt (counter + limit compare, parameterised by STARVE_LIMIT).

## Test plan
- Fetch only, 0x01000000 then 0x01000004, one per cycle: gnt each cycle; rvalid at N+2 and N+3 with the preloaded words; err=0.
- Both requesting continuously, STARVE_LIMIT=4: dm granted 4 cycles, if granted on the 5th, then dm resumes; counter returns to 0.
- Store 0xDEADBEEF, strb=4'b0011, to 0x01000010 at N; load same address at N+1: ack at N+2; load returns upper bytes old, lower 0xBEEF at N+3.
- Fetch 0x00000100 (unmapped): if_rvalid_o=1, if_err_o=1, if_rdata_o=0 at N+2.
- Fetch granted at N, if_flush_i at N+1: no if_rvalid_o at N+2; next fetch returns normally.
- rst asserted one cycle after a load grant: no dm_rvalid_o after release; all outputs 0 during reset.
